// File: rtl/svo_vcheck_pkg.sv
// Shared types and helpers for the SVO stream checker and its stall generator.
// Cursor width matches the SVO raster coordinate width used across the SVO blocks.
package svo_vcheck_pkg;

  localparam int SVO_XYBITS = 14;

  typedef logic state_t;
  localparam state_t HUNT   = 1'b0;
  localparam state_t LOCKED = 1'b1;

  // Rotate-left-by-one then fold the pixel in.
  function automatic logic [31:0] sig_step(input logic [31:0] sig, input logic [31:0] px);
    return {sig[30:0], sig[31]} ^ px;
  endfunction

  function automatic logic [31:0] xorshift32(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

endpackage

// File: rtl/svo_stall_lfsr.sv
// Pseudo-random ready generator for SVO sinks: xorshift32 stepping every cycle,
// ready is asserted whenever either of the two low state bits is set (~75%).
module svo_stall_lfsr
  import svo_vcheck_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h1
) (
  input  logic clk,
  input  logic resetn,
  output logic o_ready
);

  logic [31:0] r_lfsr;
  logic        r_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_lfsr  <= SEED;
      r_ready <= 1'b0;
    end else begin
      r_lfsr  <= xorshift32(r_lfsr);
      r_ready <= r_lfsr[0] | r_lfsr[1];
    end
  end

  assign o_ready = r_ready;

endmodule

// File: rtl/svo_vcheck.sv
// SVO stream sink: locks onto frame starts, checks raster framing and produces a
// rotate-xor signature of every complete frame.
module svo_vcheck
  import svo_vcheck_pkg::*;
#(
  parameter int          SVO_HOR_PIXELS     = 640,
  parameter int          SVO_VER_PIXELS     = 480,
  parameter int          SVO_BITS_PER_PIXEL = 24,
  parameter bit          STALL_EN           = 1'b0,
  parameter logic [31:0] STALL_SEED         = 32'h1
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          in_axis_tvalid,
  output logic                          in_axis_tready,
  input  logic [SVO_BITS_PER_PIXEL-1:0] in_axis_tdata,
  input  logic                          in_axis_tuser,
  output logic                          locked,
  output logic                          frame_done,
  output logic [31:0]                   frame_sig,
  output logic [15:0]                   frame_count,
  output logic                          err_early_sof,
  output logic                          err_missing_sof
);

  localparam logic [SVO_XYBITS-1:0] HLAST = SVO_XYBITS'(SVO_HOR_PIXELS - 1);
  localparam logic [SVO_XYBITS-1:0] VLAST = SVO_XYBITS'(SVO_VER_PIXELS - 1);

  state_t                r_state, w_state_nxt;
  logic [SVO_XYBITS-1:0] r_hcur, r_vcur;
  logic [31:0]           r_sig, r_frame_sig;
  logic [15:0]           r_count;
  logic                  r_done, r_early, r_missing;

  logic        w_acc, w_origin, w_start, w_early, w_missing, w_last, w_normal;
  logic [31:0] w_px, w_sig_next;

  // tready is purely registered so it never depends on tvalid.
  generate
    if (STALL_EN) begin : g_stall
      svo_stall_lfsr #(.SEED(STALL_SEED)) u_stall (
        .clk     (clk),
        .resetn  (resetn),
        .o_ready (in_axis_tready)
      );
    end else begin : g_nostall
      logic r_tready;
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_tready <= 1'b0;
        else         r_tready <= 1'b1;
      end
      assign in_axis_tready = r_tready;
    end
  endgenerate

  assign w_acc      = in_axis_tvalid & in_axis_tready;
  assign w_origin   = (r_hcur == '0) && (r_vcur == '0);
  assign w_px       = 32'(in_axis_tdata);
  assign w_sig_next = sig_step(r_sig, w_px);

  // Event decode; precedence early_sof > missing_sof > last pixel.
  always_comb begin
    w_start   = w_acc && (r_state == HUNT) && in_axis_tuser;
    w_early   = w_acc && (r_state == LOCKED) && in_axis_tuser && !w_origin;
    w_missing = w_acc && (r_state == LOCKED) && !in_axis_tuser && w_origin;
    w_last    = w_acc && (r_state == LOCKED) && !in_axis_tuser && !w_origin &&
                (r_hcur == HLAST) && (r_vcur == VLAST);
    w_normal  = w_acc && (r_state == LOCKED) && !w_early && !w_missing && !w_last;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= HUNT;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_start)   w_state_nxt = LOCKED;
    if (w_missing) w_state_nxt = HUNT;
  end

  assign locked = (r_state == LOCKED);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hcur      <= '0;
      r_vcur      <= '0;
      r_sig       <= '0;
      r_frame_sig <= '0;
      r_count     <= '0;
      r_done      <= 1'b0;
      r_early     <= 1'b0;
      r_missing   <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_early   <= w_early;
      r_missing <= w_missing;
      if (w_start || w_early) begin
        // This beat becomes pixel (0,0) of a fresh frame.
        r_sig  <= w_px;
        r_hcur <= SVO_XYBITS'(1);
        r_vcur <= '0;
      end else if (w_last) begin
        r_frame_sig <= w_sig_next;
        r_count     <= r_count + 16'd1;
        r_done      <= 1'b1;
        r_sig       <= '0;
        r_hcur      <= '0;
        r_vcur      <= '0;
      end else if (w_normal) begin
        r_sig <= w_sig_next;
        if (r_hcur == HLAST) begin
          r_hcur <= '0;
          r_vcur <= r_vcur + 1'b1;
        end else begin
          r_hcur <= r_hcur + 1'b1;
        end
      end
    end
  end

  assign frame_done      = r_done;
  assign frame_sig       = r_frame_sig;
  assign frame_count     = r_count;
  assign err_early_sof   = r_early;
  assign err_missing_sof = r_missing;

endmodule

// File: tb/tb_svo_vcheck.sv
// Directed bench for svo_vcheck on a 4x2 raster: one unstalled and one stalled instance.
module tb_svo_vcheck;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        a_valid, a_tready, a_user, a_locked, a_done, a_early, a_miss;
  logic [23:0] a_data;
  logic [31:0] a_sig;
  logic [15:0] a_count;
  logic        b_valid, b_tready, b_user, b_locked, b_done, b_early, b_miss;
  logic [23:0] b_data;
  logic [31:0] b_sig;
  logic [15:0] b_count;

  svo_vcheck #(.SVO_HOR_PIXELS(4), .SVO_VER_PIXELS(2), .SVO_BITS_PER_PIXEL(24),
               .STALL_EN(1'b0), .STALL_SEED(32'h1)) u_a (
    .clk(clk), .resetn(resetn),
    .in_axis_tvalid(a_valid), .in_axis_tready(a_tready),
    .in_axis_tdata(a_data), .in_axis_tuser(a_user),
    .locked(a_locked), .frame_done(a_done), .frame_sig(a_sig), .frame_count(a_count),
    .err_early_sof(a_early), .err_missing_sof(a_miss));

  svo_vcheck #(.SVO_HOR_PIXELS(4), .SVO_VER_PIXELS(2), .SVO_BITS_PER_PIXEL(24),
               .STALL_EN(1'b1), .STALL_SEED(32'h1)) u_b (
    .clk(clk), .resetn(resetn),
    .in_axis_tvalid(b_valid), .in_axis_tready(b_tready),
    .in_axis_tdata(b_data), .in_axis_tuser(b_user),
    .locked(b_locked), .frame_done(b_done), .frame_sig(b_sig), .frame_count(b_count),
    .err_early_sof(b_early), .err_missing_sof(b_miss));

  int n_vec = 0, n_err = 0;
  int a_done_n = 0, a_early_n = 0, a_miss_n = 0;
  int b_done_n = 0, b_errp_n = 0, b_stall_n = 0;

  always @(negedge clk) begin
    if (a_done)  a_done_n++;
    if (a_early) a_early_n++;
    if (a_miss)  a_miss_n++;
    if (b_done)  b_done_n++;
    if (b_early || b_miss) b_errp_n++;
    if (resetn && !b_tready) b_stall_n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a beat and hold it until accepted; returns 1ns after the accepting edge.
  task automatic beat(input bit s, input logic [23:0] d, input logic u);
    int  t;
    bit  rdy;
    t = 0;
    if (s) begin b_valid = 1'b1; b_data = d; b_user = u; end
    else   begin a_valid = 1'b1; a_data = d; a_user = u; end
    rdy = 1'b0;
    while (!rdy && t < 200) begin
      @(negedge clk);
      t++;
      rdy = s ? b_tready : a_tready;
    end
    if (!rdy) chk("beat_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input bit s, input int n);
    if (s) b_valid = 1'b0; else a_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input bit s, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) idle(s, $urandom_range(1, 3));
      beat(s, 24'(i), (i == 0));
    end
  endtask

  initial begin
    int dn;
    resetn = 1'b0;
    a_valid = 1'b0; a_data = '0; a_user = 1'b0;
    b_valid = 1'b0; b_data = '0; b_user = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tready", a_tready, 0);
    chk("rst_locked", a_locked, 0);
    chk("rst_pulses", {a_done, a_early, a_miss}, 0);
    chk("rst_count", a_count, 0);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    chk("tready_after_rst", a_tready, 1);
    chk("locked_idle", a_locked, 0);

    // Leading non-SOF beats are dropped while hunting.
    beat(0, 24'h55, 1'b0);
    beat(0, 24'h66, 1'b0);
    chk("hunt_discard_locked", a_locked, 0);
    frame(0, 1'b0);
    chk("f1_done", a_done, 1);
    chk("f1_sig", a_sig, 32'h0000000F);
    chk("f1_count", a_count, 1);
    chk("f1_locked", a_locked, 1);
    idle(0, 1);
    chk("f1_done_1cyc", a_done, 0);

    frame(0, 1'b0);
    chk("f2_sig", a_sig, 32'h0000000F);
    chk("f2_count", a_count, 2);

    // SOF arrives at beat 5, restarting the frame with pixel 5.
    for (int i = 0; i < 5; i++) beat(0, 24'(i), (i == 0));
    beat(0, 24'd5, 1'b1);
    chk("early_pulse", a_early, 1);
    chk("early_count_hold", a_count, 2);
    for (int i = 1; i < 7; i++) beat(0, 24'(i), 1'b0);
    chk("early_no_done", a_done, 0);
    beat(0, 24'd7, 1'b0);
    chk("restart_done", a_done, 1);
    chk("restart_sig", a_sig, 32'h0000028F);
    chk("restart_count", a_count, 3);

    // Non-SOF beat where a frame should start.
    beat(0, 24'h9, 1'b0);
    chk("missing_pulse", a_miss, 1);
    chk("missing_unlock", a_locked, 0);
    chk("sig_hold", a_sig, 32'h0000028F);
    frame(0, 1'b0);
    chk("relock_locked", a_locked, 1);
    chk("relock_sig", a_sig, 32'h0000000F);
    chk("relock_count", a_count, 4);
    idle(0, 2);
    chk("a_done_total", a_done_n, 4);
    chk("a_early_total", a_early_n, 1);
    chk("a_miss_total", a_miss_n, 1);

    // Reset in mid-frame drops everything.
    for (int i = 0; i < 3; i++) beat(0, 24'(i), (i == 0));
    a_valid = 1'b0;
    dn = a_done_n + a_early_n + a_miss_n;
    @(negedge clk) resetn = 1'b0;
    #1;
    chk("midrst_locked", a_locked, 0);
    chk("midrst_count", a_count, 0);
    chk("midrst_sig", a_sig, 0);
    chk("midrst_tready", a_tready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    idle(0, 2);
    chk("midrst_no_pulse", a_done_n + a_early_n + a_miss_n, dn);

    // Stalled instance must see the identical frame content.
    beat(1, 24'h33, 1'b0);
    frame(1, 1'b1);
    chk("stall_done", b_done, 1);
    chk("stall_sig", b_sig, 32'h0000000F);
    chk("stall_count", b_count, 1);
    frame(1, 1'b1);
    chk("stall_sig2", b_sig, 32'h0000000F);
    idle(1, 3);
    chk("stall_done_total", b_done_n, 2);
    chk("stall_no_err", b_errp_n, 0);
    chk("stall_seen", (b_stall_n != 0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
